// File: rtl/fwd_pkg.sv
// Shared types and constants for the OTTER forwarding/hazard controller.
// Select encodings, the in-flight tag layout and opcodes the decoder uses to form ID_RS_USED.
package fwd_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } tag_t;

   localparam int SEL_RF  = 0;
   localparam int SEL_MEM = 1;
   localparam int SEL_WB  = 2;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Store data travels straight to memory, so only its address operand reaches the ALU.
   function automatic logic [1:0] rs_used(input logic [6:0] opcode);
      logic [1:0] used;
      used = 2'b00;
      case (opcode)
         OP_REG, OP_BRANCH:                used = 2'b11;
         OP_LOAD, OP_STORE, OP_IMM, OP_JALR: used = 2'b01;
         default:                          used = 2'b00;
      endcase
      return used;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Finds the youngest in-flight producer of one source register.
// Purely combinational; idx_o is the tag's current position (0 = EX).
module fwd_match
   import fwd_pkg::*;
#(
   parameter int NT    = 2,
   parameter int RA_W  = 5,
   parameter int SEL_W = 2
) (
   input  logic [NT-1:0]      tag_vld_i,
   input  logic [NT*RA_W-1:0] tag_rd_i,
   input  logic [NT-1:0]      tag_wr_i,
   input  logic [NT-1:0]      tag_ld_i,
   input  logic [RA_W-1:0]    rs_i,
   input  logic               used_i,
   output logic               hit_o,
   output logic [SEL_W-1:0]   idx_o,
   output logic               is_load_o
);

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      hit_o     = 1'b0;
      idx_o     = SEL_W'(SEL_RF);
      is_load_o = 1'b0;
      for (int i = NT - 1; i >= 0; i--) begin
         if (used_i && tag_vld_i[i] && tag_wr_i[i] && (tag_rd_i[i*RA_W +: RA_W] == rs_i)) begin
            hit_o     = 1'b1;
            idx_o     = SEL_W'(i);
            is_load_o = tag_ld_i[i];
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the OTTER pipeline.
// Tracks destination tags of in-flight instructions and issues registered ALU forwarding selects.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int LOAD_IDX = 2,
   parameter int RA_W     = 5,
   parameter int SEL_W    = $clog2(DEPTH)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ID_VALID,
   input  logic [NUM_SRC*RA_W-1:0]  ID_RS,
   input  logic [NUM_SRC-1:0]       ID_RS_USED,
   input  logic [RA_W-1:0]          ID_RD,
   input  logic                     ID_REGWRITE,
   input  logic                     ID_IS_LOAD,
   input  logic                     MEM_READY,
   input  logic                     FLUSH,
   output logic                     STALL,
   output logic                     FREEZE,
   output logic [NUM_SRC*SEL_W-1:0] EX_SEL,
   output logic [31:0]              STALL_CNT
);

   // The oldest stage never needs a tag: the register file is write-first.
   localparam int NT = DEPTH - 1;

   if (DEPTH < SEL_WB) begin : g_bad_depth
      $error("fwd_hazard_unit: DEPTH must be at least 2");
   end
   if (LOAD_IDX < SEL_MEM || LOAD_IDX > DEPTH - 1) begin : g_bad_load_idx
      $error("fwd_hazard_unit: LOAD_IDX must lie in 1..DEPTH-1");
   end

   logic [NT-1:0]            vld_q, vld_d;
   logic [NT-1:0]            wr_q, wr_d;
   logic [NT-1:0]            ld_q, ld_d;
   logic [NT*RA_W-1:0]       rd_q, rd_d;
   logic [NUM_SRC*SEL_W-1:0] ex_sel_q, ex_sel_d;
   logic [31:0]              cnt_q, cnt_d;

   logic [NUM_SRC-1:0]       hit, hit_ld;
   logic [NUM_SRC*SEL_W-1:0] hit_idx;
   logic                     load_hz;
   logic                     bubble;

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_match #(
         .NT   (NT),
         .RA_W (RA_W),
         .SEL_W(SEL_W)
      ) u_match (
         .tag_vld_i(vld_q),
         .tag_rd_i (rd_q),
         .tag_wr_i (wr_q),
         .tag_ld_i (ld_q),
         .rs_i     (ID_RS[k*RA_W +: RA_W]),
         .used_i   (ID_RS_USED[k]),
         .hit_o    (hit[k]),
         .idx_o    (hit_idx[k*SEL_W +: SEL_W]),
         .is_load_o(hit_ld[k])
      );
   end

   // A load is usable once it would sit at LOAD_IDX or later when this instruction enters EX.
   always_comb begin
      load_hz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (hit[k] && hit_ld[k] && ((int'(hit_idx[k*SEL_W +: SEL_W]) + 1) < LOAD_IDX)) begin
            load_hz = 1'b1;
         end
      end
   end

   assign STALL     = ID_VALID && !FLUSH && load_hz;
   assign FREEZE    = ~MEM_READY;
   assign bubble    = ~ID_VALID | STALL | FLUSH;
   assign EX_SEL    = ex_sel_q;
   assign STALL_CNT = cnt_q;

   always_comb begin
      vld_d    = vld_q;
      wr_d     = wr_q;
      ld_d     = ld_q;
      rd_d     = rd_q;
      ex_sel_d = ex_sel_q;
      cnt_d    = cnt_q;
      if (MEM_READY) begin
         for (int i = NT - 1; i >= 1; i--) begin
            vld_d[i]              = vld_q[i-1];
            wr_d[i]               = wr_q[i-1];
            ld_d[i]               = ld_q[i-1];
            rd_d[i*RA_W +: RA_W]  = rd_q[(i-1)*RA_W +: RA_W];
         end
         vld_d[0]      = ~bubble;
         wr_d[0]       = ID_REGWRITE && (ID_RD != '0);
         ld_d[0]       = ID_IS_LOAD;
         rd_d[0 +: RA_W] = ID_RD;
         for (int k = 0; k < NUM_SRC; k++) begin
            if (!bubble && hit[k]) begin
               ex_sel_d[k*SEL_W +: SEL_W] = hit_idx[k*SEL_W +: SEL_W] + 1'b1;
            end else begin
               ex_sel_d[k*SEL_W +: SEL_W] = SEL_W'(SEL_RF);
            end
         end
         if (STALL) begin
            cnt_d = sat_inc(cnt_q);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q    <= '0;
         ex_sel_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         ex_sel_q <= ex_sel_d;
         cnt_q    <= cnt_d;
      end
   end

   // Tag payload is qualified by vld_q, so it carries no reset.
   always_ff @(posedge CLK) begin
      wr_q <= wr_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a default instance and a DEPTH=4/LOAD_IDX=3 instance share stimulus,
// each compared against a queue-based model of in-flight instructions.
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_regwrite, id_is_load, mem_ready, flush;
   logic [9:0] id_rs;
   logic [1:0] id_rs_used;
   logic [4:0] id_rd;
   logic       stall_a, freeze_a, stall_b, freeze_b;
   logic [3:0] ex_sel_a, ex_sel_b;
   logic [31:0] cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(3), .LOAD_IDX(2), .RA_W(5)) dut_a (
      .CLK(clk), .RST(rst), .ID_VALID(id_valid), .ID_RS(id_rs), .ID_RS_USED(id_rs_used),
      .ID_RD(id_rd), .ID_REGWRITE(id_regwrite), .ID_IS_LOAD(id_is_load),
      .MEM_READY(mem_ready), .FLUSH(flush), .STALL(stall_a), .FREEZE(freeze_a),
      .EX_SEL(ex_sel_a), .STALL_CNT(cnt_a)
   );

   fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(4), .LOAD_IDX(3), .RA_W(5)) dut_b (
      .CLK(clk), .RST(rst), .ID_VALID(id_valid), .ID_RS(id_rs), .ID_RS_USED(id_rs_used),
      .ID_RD(id_rd), .ID_REGWRITE(id_regwrite), .ID_IS_LOAD(id_is_load),
      .MEM_READY(mem_ready), .FLUSH(flush), .STALL(stall_b), .FREEZE(freeze_b),
      .EX_SEL(ex_sel_b), .STALL_CNT(cnt_b)
   );

   // Model: per instance, a queue of issued instructions, youngest at the front.
   typedef struct packed {
      bit       v;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
   } mtag_t;

   mtag_t           mq[2][$];
   int              md[2];
   int              ml[2];
   int              msel[2][2];
   bit              mstall[2];
   int              mex[2][2];
   longint unsigned mcnt[2];
   bit              last_stall[2];

   function automatic void eval(int n);
      bit hz;
      hz = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bit mld;
         mld = 1'b0;
         msel[n][k] = 0;
         if (id_rs_used[k]) begin
            for (int j = 0; j < mq[n].size() && j < md[n] - 1; j++) begin
               if (mq[n][j].v && mq[n][j].wr && mq[n][j].rd == id_rs[k*5 +: 5]) begin
                  msel[n][k] = j + 1;
                  mld = mq[n][j].ld;
                  break;
               end
            end
         end
         if (mld && msel[n][k] < ml[n]) hz = 1'b1;
      end
      mstall[n] = id_valid && !flush && hz;
   endfunction

   function automatic void update(int n);
      if (rst) begin
         mq[n].delete();
         mex[n][0] = 0;
         mex[n][1] = 0;
         mcnt[n] = 0;
      end else if (mem_ready) begin
         bit bub;
         mtag_t t;
         bub  = !id_valid || mstall[n] || flush;
         t.v  = !bub;
         t.rd = id_rd;
         t.wr = id_regwrite && (id_rd != 5'd0);
         t.ld = id_is_load;
         mq[n].push_front(t);
         while (mq[n].size() > md[n]) void'(mq[n].pop_back());
         for (int k = 0; k < 2; k++) mex[n][k] = bub ? 0 : msel[n][k];
         if (mstall[n] && mcnt[n] != 64'h0000_0000_FFFF_FFFF) mcnt[n]++;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit v, input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
                      input logic [4:0] rd, input bit w, input bit l, input bit mr, input bit fl);
      id_valid = v; id_rs = {r1, r0}; id_rs_used = u; id_rd = rd;
      id_regwrite = w; id_is_load = l; mem_ready = mr; flush = fl;
      #3;
      eval(0); eval(1);
      chk("stall_a", 32'(stall_a), 32'(mstall[0]));
      chk("stall_b", 32'(stall_b), 32'(mstall[1]));
      chk("freeze_a", 32'(freeze_a), 32'(!mr));
      chk("freeze_b", 32'(freeze_b), 32'(!mr));
      last_stall[0] = stall_a;
      last_stall[1] = stall_b;
      @(posedge clk);
      update(0); update(1);
      #1;
      chk("exsel_a0", 32'(ex_sel_a[1:0]), 32'(mex[0][0]));
      chk("exsel_a1", 32'(ex_sel_a[3:2]), 32'(mex[0][1]));
      chk("exsel_b0", 32'(ex_sel_b[1:0]), 32'(mex[1][0]));
      chk("exsel_b1", 32'(ex_sel_b[3:2]), 32'(mex[1][1]));
      chk("cnt_a", cnt_a, mcnt[0][31:0]);
      chk("cnt_b", cnt_b, mcnt[1][31:0]);
   endtask

   task automatic op(input bit v, input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
                     input logic [4:0] rd, input bit w, input bit l);
      cyc(v, r0, r1, u, rd, w, l, 1'b1, 1'b0);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      cyc(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      md[0] = 3; ml[0] = 2;
      md[1] = 4; ml[1] = 3;
      rst = 1'b1;
      id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
      id_regwrite = 1'b0; id_is_load = 1'b0; mem_ready = 1'b1; flush = 1'b0;

      do_rst();
      chk("rst_exsel_a", 32'(ex_sel_a), 32'd0);
      chk("rst_cnt_a", cnt_a, 32'd0);

      // ADD x5 ; SUB x6,x5,x1
      op(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0);
      op(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0);
      chk("t1_sel_a", 32'(ex_sel_a), 32'h1);
      chk("t1_sel_b", 32'(ex_sel_b), 32'h1);
      chk("t1_nostall", 32'(last_stall[0]), 32'd0);

      // ADD x5 ; NOP ; OR x7,x5,x5
      op(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0);
      op(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0);
      op(1, 5'd5, 5'd5, 2'b11, 5'd7, 1, 0);
      chk("t2_sel_a", 32'(ex_sel_a), 32'hA);
      chk("t2_sel_b", 32'(ex_sel_b), 32'hA);
      chk("t2_cnt", cnt_a, 32'd0);

      // LW x5 ; ADD x6,x5,x0 held while stalled
      do_rst();
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      op(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0);
      chk("t3_stall1_a", 32'(last_stall[0]), 32'd1);
      chk("t3_stall1_b", 32'(last_stall[1]), 32'd1);
      chk("t3_bubble_a", 32'(ex_sel_a), 32'd0);
      op(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0);
      chk("t3_stall2_a", 32'(last_stall[0]), 32'd0);
      chk("t3_stall2_b", 32'(last_stall[1]), 32'd1);
      chk("t3_sel_a", 32'(ex_sel_a[1:0]), 32'd2);
      chk("t3_cnt_a", cnt_a, 32'd1);
      op(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0);
      chk("t3_stall3_b", 32'(last_stall[1]), 32'd0);
      chk("t3_sel_b", 32'(ex_sel_b[1:0]), 32'd3);
      chk("t3_cnt_b", cnt_b, 32'd2);

      // LW x5 ; ADDI x5,x5,1 ; ADD x8,x5,x0 -> younger ADDI shadows the load
      do_rst();
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      repeat (3) op(1, 5'd5, 5'd0, 2'b01, 5'd5, 1, 0);
      op(1, 5'd5, 5'd0, 2'b11, 5'd8, 1, 0);
      chk("t4_nostall_a", 32'(last_stall[0]), 32'd0);
      chk("t4_nostall_b", 32'(last_stall[1]), 32'd0);
      chk("t4_sel_a", 32'(ex_sel_a[1:0]), 32'd1);
      chk("t4_sel_b", 32'(ex_sel_b[1:0]), 32'd1);
      // Load into x0, then read x0
      op(1, 5'd1, 5'd2, 2'b01, 5'd0, 1, 1);
      op(1, 5'd0, 5'd0, 2'b11, 5'd9, 1, 0);
      chk("t4_x0_stall", 32'(last_stall[0]), 32'd0);
      chk("t4_x0_sel", 32'(ex_sel_a), 32'd0);

      // Load-use hazard under a 3-cycle freeze
      do_rst();
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      repeat (3) cyc(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 1'b0, 1'b0);
      chk("t5_frz_stall", 32'(last_stall[0]), 32'd1);
      chk("t5_frz_cnt", cnt_a, 32'd0);
      chk("t5_frz_sel", 32'(ex_sel_a), 32'd0);
      op(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0);
      chk("t5_res_cnt", cnt_a, 32'd1);
      op(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0);
      chk("t5_res_sel", 32'(ex_sel_a[1:0]), 32'd2);

      // FLUSH beats a load-use hazard
      do_rst();
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      cyc(1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 1'b1, 1'b1);
      chk("t6_stall_a", 32'(last_stall[0]), 32'd0);
      chk("t6_stall_b", 32'(last_stall[1]), 32'd0);
      chk("t6_sel_a", 32'(ex_sel_a), 32'd0);
      chk("t6_cnt", cnt_a, 32'd0);

      // Reset with a load in flight
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      op(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
      do_rst();
      chk("t7_cnt_a", cnt_a, 32'd0);
      op(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0);
      chk("t7_stall", 32'(last_stall[0]), 32'd0);
      chk("t7_sel_a", 32'(ex_sel_a), 32'd0);
      chk("t7_sel_b", 32'(ex_sel_b), 32'd0);

      // Randomised traffic over a small register set to provoke collisions
      repeat (500) begin
         rst = ($urandom_range(0, 63) == 0);
         cyc($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the OTTER pipeline. Successor to the fixed two-stage, two-source forwarding logic.
- Keeps its own shift register of in-flight destination tags, one entry per post-ID stage: index 0=EX, 1=MEM, 2=WB, up to DEPTH-1.
- From that state it produces:
  - registered per-source forwarding selects for the instruction entering EX;
  - a load-use stall with configurable load-data latency;
  - a whole-pipe freeze driven by a memory handshake;
  - a saturating stall-cycle counter.

Parameters:
- NUM_SRC, 2, number of source operands per instruction.
- DEPTH, 3, number of tracked stages after ID (EX..WB); must be >=2.
- LOAD_IDX, 2, lowest stage index at which load data can be forwarded; range 1..DEPTH-1.
- RA_W, 5, register address width.
- SEL_W, $clog2(DEPTH), derived, forwarding select width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_RS  in  NUM_SRC*RA_W  source register addresses; source k is at [k*RA_W +: RA_W].
- ID_RS_USED  in  NUM_SRC  source k is actually read (stores set this 0 for the data operand to the ALU).
- ID_RD  in  RA_W  destination register.
- ID_REGWRITE  in  1  instruction writes ID_RD.
- ID_IS_LOAD  in  1  instruction is a load.
- MEM_READY  in  1  data memory handshake; 0 freezes the whole pipe.
- FLUSH  in  1  branch/jump taken in EX; kill the ID instruction.
- STALL  out  1  hold PC and IF/ID, insert a bubble into EX.
- FREEZE  out  1  equals ~MEM_READY; all pipeline registers hold.
- EX_SEL  out  NUM_SRC*SEL_W  per-source ALU mux select for the instruction in EX. 0 = register file, j = forward from stage index j.
- STALL_CNT  out  32  number of load-use stall cycles.

Behaviour:
- Entry format: {valid, rd, wr, ld}. wr = ID_REGWRITE && ID_RD!=0, so x0 never forwards and never stalls.
- Reset: all entries invalid, EX_SEL=0, STALL_CNT=0. STALL=0 and FREEZE follows MEM_READY from the next cycle.
- Advance (MEM_READY=1):
  - entry[i+1] <= entry[i];
  - entry[0] <= ID instruction, or a bubble if ~ID_VALID, STALL or FLUSH;
  - the oldest entry drops; the register file is write-first, so it needs no tracking.
- Freeze (MEM_READY=0):
  - entries, EX_SEL and STALL_CNT hold;
  - FLUSH is ignored (the branch unit holds it until the pipe moves);
  - STALL is still computed but has no effect.
- Match, per source k with ID_RS_USED[k]=1, over current indices i=0..DEPTH-2: valid && wr && rd==ID_RS[k]. The youngest (smallest i) match wins.
- Forwarding: on advance, EX_SEL[k] <= i+1 for the winning match, else 0. On a bubble insert (STALL/FLUSH/~ID_VALID) EX_SEL <= 0. Latency is 1 cycle, aligned with ID/EX.
- Load-use: STALL = ID_VALID && ~FLUSH && any source whose winning match has ld=1 and i+1 < LOAD_IDX.
  - An older load shadowed by a younger non-load match does not stall.
  - The stall repeats each cycle until the load reaches a forwardable index (LOAD_IDX-1 cycles for the default case = 1).
- FLUSH together with a STALL condition: FLUSH wins, STALL=0, bubble inserted.
- STALL_CNT increments when STALL && MEM_READY and saturates at 32'hFFFF_FFFF.
- A combinational path exists from the ID inputs to STALL. There is no combinational path from ID inputs to EX_SEL.
- RST mid-operation: all in-flight tags drop immediately and no stale forwarding is issued.

Decomposition:
- fwd_pkg holds:
  - the tag_t struct {valid, rd, wr, ld};
  - constants SEL_RF=0, SEL_MEM=1, SEL_WB=2;
  - the opcode constants used by the decoder to form ID_RS_USED (e.g. STORE=7'b0100011).
- One sub-module, fwd_match: purely combinational, one instance per source. Inputs: tag vector and rs/used. Outputs: hit, index, is_load. The top owns the shift register, STALL, EX_SEL regs and the counter.

Test Plan:
- ADD x5 then next-cycle SUB x6,x5,x1 -> EX_SEL[0]=1 when SUB is in EX, STALL never asserted.
- ADD x5; NOP; OR x7,x5,x5 -> EX_SEL=2 for both sources, 0 stalls.
- LW x5 then ADD x6,x5,x0 (LOAD_IDX=2) -> STALL=1 for exactly 1 cycle, bubble in EX, then EX_SEL[0]=2, STALL_CNT=1. Repeat with LOAD_IDX=3, DEPTH=4 -> 2 stall cycles, then EX_SEL=3.
- LW x5; ADDI x5,x5,1; ADD x8,x5,x0 -> ADD takes EX_SEL=1 (ADDI), no stall. Also write to x0 followed by a read of x0 -> EX_SEL=0, no stall.
- Load-use hazard with MEM_READY=0 for 3 cycles -> FREEZE=1 and all outputs/STALL_CNT hold, then resume. STALL_CNT counts only unfrozen stall cycles.
- FLUSH asserted while a load-use hazard is present -> STALL=0, bubble enters EX, EX_SEL=0. RST during an in-flight load -> next cycle EX_SEL=0, STALL=0, STALL_CNT=0.
